// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator result display
package calc_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_ONES = 2'd0,
        SEL_TENS = 2'd1,
        SEL_SIGN = 2'd2
    } digit_sel_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_BLANK = 4'hF;
    localparam digit_t DIGIT_MINUS = 4'hE;

    localparam int DIGIT_COUNT   = 3;
    localparam int BIN_WIDTH     = 6;
    localparam int CONVERT_STEPS = 6;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One double-dabble step on {tens[2:0], ones[3:0]}; returns {tens, ones}.
    // Magnitudes never exceed 32, so tens stays below 5 and never needs correction.
    function automatic logic [7:0] dd_step(input logic [6:0] bcd, input logic bit_in);
        logic [3:0] ones_adj;
        ones_adj = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
        return {bcd[6:4], ones_adj, bit_in};
    endfunction

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - load/status and display bus of the result display
interface result_display_if;
    logic       load;
    logic [5:0] value;
    logic       busy;
    logic       done;
    logic [2:0] an;
    logic [6:0] seg;

    modport master (
        output load,
        output value,
        input  busy,
        input  done,
        input  an,
        input  seg
    );

    modport slave (
        input  load,
        input  value,
        output busy,
        output done,
        output an,
        output seg
    );
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - digit code to active-low seven-segment pattern
module seg7_decoder
    import calc_pkg::*;
(
    input  digit_t     code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:        seg = SEG_0;
            4'd1:        seg = SEG_1;
            4'd2:        seg = SEG_2;
            4'd3:        seg = SEG_3;
            4'd4:        seg = SEG_4;
            4'd5:        seg = SEG_5;
            4'd6:        seg = SEG_6;
            4'd7:        seg = SEG_7;
            4'd8:        seg = SEG_8;
            4'd9:        seg = SEG_9;
            DIGIT_MINUS: seg = SEG_MINUS;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - signed 6-bit result to BCD, multiplexed onto three 7-segment digits
module result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    result_display_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t                 state_q, state_d;
    logic                   busy;
    logic                   capture;
    logic                   last_step;
    logic                   done_q;
    logic [2:0]             step_q;
    logic                   neg_q;
    logic [BIN_WIDTH-1:0]   bin_q;
    logic [6:0]             bcd_q;
    logic [7:0]             bcd_next;
    logic [BIN_WIDTH-1:0]   mag;

    digit_t                 ones_q, tens_q, sign_q;
    digit_t                 ones_d, tens_d, sign_d;

    logic [CNT_W-1:0]       scan_q;
    logic                   scan_wrap;
    digit_sel_t             sel_q, sel_d;
    digit_t                 code;
    logic [6:0]             seg_d;
    logic [DIGIT_COUNT-1:0] an_d;
    logic [DIGIT_COUNT-1:0] an_q;
    logic [6:0]             seg_q;

    // -32 negates to 6'b100000, which read unsigned is the required 32
    assign mag      = bus.value[5] ? (~bus.value + 6'd1) : bus.value;
    assign bcd_next = dd_step(bcd_q, bin_q[BIN_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.load) state_d = ST_CONVERT;
            ST_CONVERT: if (step_q == 3'(CONVERT_STEPS - 1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_CONVERT);
        capture   = (state_q == ST_IDLE) && bus.load;
        last_step = (state_q == ST_CONVERT) && (step_q == 3'(CONVERT_STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            step_q <= 3'd0;
            neg_q  <= 1'b0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else begin
            done_q <= last_step;
            if (capture) begin
                neg_q  <= bus.value[5];
                bin_q  <= mag;
                bcd_q  <= '0;
                step_q <= 3'd0;
            end else if (busy) begin
                bin_q  <= {bin_q[BIN_WIDTH-2:0], 1'b0};
                bcd_q  <= bcd_next[6:0];
                step_q <= step_q + 3'd1;
            end
        end
    end

    // Next display contents; the last step's result goes straight to the digits
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        sign_d = sign_q;
        if (last_step) begin
            ones_d = bcd_next[3:0];
            tens_d = (bcd_next[7:4] == 4'd0) ? DIGIT_BLANK : bcd_next[7:4];
            sign_d = neg_q ? DIGIT_MINUS : DIGIT_BLANK;
        end
    end

    assign scan_wrap = (scan_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        sel_d = sel_q;
        if (scan_wrap) begin
            case (sel_q)
                SEL_ONES: sel_d = SEL_TENS;
                SEL_TENS: sel_d = SEL_SIGN;
                default:  sel_d = SEL_ONES;
            endcase
        end
    end

    // an and seg are both computed from the next selection so they change on the same edge
    always_comb begin
        code = ones_d;
        case (sel_d)
            SEL_TENS: code = tens_d;
            SEL_SIGN: code = sign_d;
            default:  code = ones_d;
        endcase
        an_d = ~(DIGIT_COUNT'(1) << sel_d);
    end

    seg7_decoder u_seg7_decoder (
        .code (code),
        .seg  (seg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q <= '0;
            sel_q  <= SEL_ONES;
            an_q   <= 3'b110;
            seg_q  <= SEG_0;
            ones_q <= 4'd0;
            tens_q <= DIGIT_BLANK;
            sign_q <= DIGIT_BLANK;
        end else begin
            scan_q <= scan_wrap ? '0 : (scan_q + CNT_W'(1));
            sel_q  <= sel_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            sign_q <= sign_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles each digit stays lit (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port load  input  1  request to convert value; accepted only when busy=0.
REQ-005 SHALL have port value  input  6  signed two's-complement calculator result, range -32..+31.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when new digits become visible.
REQ-008 SHALL have port an  output  3  active-low digit enables: [0] ones, [1] tens, [2] sign.
REQ-009 SHALL have port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Function
REQ-010 SHALL run FSM states IDLE and CONVERT only.
REQ-011 IDLE with load=1 at edge N: SHALL capture magnitude |value| (7-bit, so -32 -> 32) and sign, then enter CONVERT.
REQ-012 CONVERT SHALL run 6 shift-add-3 (double-dabble) iterations, one per cycle, with busy=1 during cycles N+1..N+6.
REQ-013 At edge N+6 SHALL load the display registers, pulse done high for cycle N+7, and return to IDLE (busy=0 in cycle N+7).
REQ-014 load while busy=1 SHALL be ignored, with no queueing and no effect on the in-flight conversion.
REQ-015 load in the cycle done is high SHALL be accepted, since busy=0.
REQ-016 Display registers SHALL hold the previous result unchanged throughout CONVERT.
REQ-017 Ones digit SHALL always show a decimal 0-9.
REQ-018 Tens digit SHALL be blank when zero (leading-zero suppression).
REQ-019 Sign digit SHALL show '-' (segment g only, seg=7'b0111111) when negative, blank (7'b1111111) otherwise.
REQ-020 Zero SHALL display as blank, blank, '0'; -0 is impossible.
REQ-021 A scan counter 0..REFRESH_DIV-1 SHALL advance the digit index on wrap: ones -> tens -> sign -> ones.
REQ-022 Exactly one an bit SHALL be low at any time.
REQ-023 seg SHALL be the pattern of the selected digit, registered together with an so no ghosting cycle occurs.
REQ-024 Scanning SHALL continue uninterrupted during conversion.

Reset
REQ-025 rst_n=0 at an edge SHALL force: FSM=IDLE, busy=0, done=0, scan counter=0, digit index=ones, an=3'b110, seg=7'b1000000 ('0'), display registers = blank/blank/0.
REQ-026 Reset mid-CONVERT SHALL abandon the conversion without asserting done.
REQ-027 load SHALL be ignored while rst_n=0.

Structure
REQ-028 Shared package calc_pkg SHALL hold: FSM state enum, 4-bit digit code type with a BLANK code (4'hF), segment constants for 0-9, MINUS and BLANK, and DIGIT_COUNT=3.
REQ-029 SHALL instantiate one combinational sub-module seg7_decoder (4-bit digit code -> 7-bit active-low segments, BLANK and MINUS codes supported), shared by all three digits through the scan mux.

Verification
REQ-030 load with value=6'sd31 -> done at N+7; scan shows ones '1' (7'b1111001), tens '3' (7'b0110000), sign blank.
REQ-031 load with value=-32 (6'b100000) -> digits '-','3','2'; ones seg=7'b0100100.
REQ-032 load with value=0, then value=-5 -> first blank/blank/'0'; then '-', blank, '5' (7'b0010010).
REQ-033 With REFRESH_DIV=4: an sequence 110,101,011 with each value held exactly 4 cycles; a second load at N+3 is ignored (done count=1, digits from the first value).
REQ-034 rst_n low at N+3 of a conversion -> next cycle busy=0, done never pulses, an=3'b110, seg=7'b1000000.
